// File: rtl/instr_mem_fetch.sv
// Loadable byte-addressed, little-endian instruction memory with a registered
// fetch port (IF stage). Loader writes words through an auto-incrementing pointer.
module instr_mem_fetch #(
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned ADDR_W      = 32,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_en,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_we,
  input  logic [31:0]       ld_wdata,
  output logic [ADDR_W-1:0] ld_ptr,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  input  logic              flush,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic              fault
);

  localparam int unsigned        IDX_W     = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH_BYTES - 4);
  localparam logic [ADDR_W-1:0]  DEPTH_A   = ADDR_W'(DEPTH_BYTES);

  logic [7:0]        mem [DEPTH_BYTES];

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       rd_word;
  logic              fetch_fault;

  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  // Loader pointer: ld_start has priority and suppresses the write.
  always_comb begin
    ptr_d = ptr_q;
    wr_en = 1'b0;
    if (ld_en) begin
      if (ld_start) begin
        ptr_d = (ld_addr & ~ADDR_W'(3)) % DEPTH_A;
      end else if (ld_we) begin
        wr_en = 1'b1;
        ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign wr_idx = ptr_q[IDX_W-1:0];

  // Storage is never reset; reset_n still gates the write so a word presented
  // while reset is held is not committed.
  always_ff @(posedge clk) begin
    if (wr_en && reset_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        mem[wr_idx + IDX_W'(i)] <= ld_wdata[8*i +: 8];
      end
    end
  end

  assign rd_idx      = fetch_addr[IDX_W-1:0];
  assign rd_word     = {mem[rd_idx + IDX_W'(3)], mem[rd_idx + IDX_W'(2)],
                        mem[rd_idx + IDX_W'(1)], mem[rd_idx]};
  assign fetch_fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr > LAST_ADDR);

  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (flush || ld_en) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
    end else if (fetch_req) begin
      valid_d = 1'b1;
      fault_d = fetch_fault;
      instr_d = fetch_fault ? NOP_WORD : rd_word;
    end else begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign ld_ptr      = ptr_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Scoreboard bench for instr_mem_fetch: stimulus pushes hand-computed expected
// outputs tagged with the clock edge they apply to; a monitor pops and compares.
module tb_instr_mem_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_en, ld_start, ld_we;
  logic [31:0] ld_addr, ld_wdata, ld_ptr;
  logic        fetch_req, stall, flush;
  logic [31:0] fetch_addr, instr_out;
  logic        instr_valid, fault;

  instr_mem_fetch #(.DEPTH_BYTES(128), .ADDR_W(32), .NOP_WORD(32'h0000_0013)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ld_en      (ld_en),
    .ld_start   (ld_start),
    .ld_addr    (ld_addr),
    .ld_we      (ld_we),
    .ld_wdata   (ld_wdata),
    .ld_ptr     (ld_ptr),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .stall      (stall),
    .flush      (flush),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned tag;
    bit          is_ptr;
    bit          chk_data;
    logic        v;
    logic        f;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned edge_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic exp_out(input logic v, input logic f, input logic [31:0] d, input bit cd);
    exp_t e;
    e.tag = edge_cnt + 1; e.is_ptr = 1'b0; e.chk_data = cd;
    e.v = v; e.f = f; e.data = d;
    sb.push_back(e);
  endtask

  task automatic exp_ptr(input logic [31:0] p);
    exp_t e;
    e.tag = edge_cnt + 1; e.is_ptr = 1'b1; e.chk_data = 1'b1;
    e.v = 1'b0; e.f = 1'b0; e.data = p;
    sb.push_back(e);
  endtask

  // Monitor: compares every expectation due at the edge just taken.
  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
      e = sb.pop_front();
      if (e.tag != edge_cnt) chk("stale_expectation", 32'(e.tag), 32'(edge_cnt));
      if (e.is_ptr) begin
        chk("ld_ptr", ld_ptr, e.data);
      end else begin
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, e.v});
        chk("fault", {31'b0, fault}, {31'b0, e.f});
        if (e.chk_data) chk("instr_out", instr_out, e.data);
      end
    end
  end

  task automatic next;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] a);
    ld_en = 0; ld_start = 0; ld_we = 0; stall = 0; flush = 0;
    fetch_req = 1; fetch_addr = a;
  endtask

  initial begin
    reset_n = 0; ld_en = 0; ld_start = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    fetch_req = 0; fetch_addr = '0; stall = 0; flush = 0;
    next; next;
    chk("rst_instr", instr_out, NOP);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_ptr", ld_ptr, 32'd0);
    reset_n = 1;
    next;

    // Loader: start at 0 (fetch request blocked while loading), two words.
    ld_en = 1; ld_start = 1; ld_addr = 32'h0; fetch_req = 1; fetch_addr = 32'h0;
    exp_out(0, 0, NOP, 1); exp_ptr(32'h0); next;
    ld_start = 0; ld_we = 1; ld_wdata = 32'h0140_2103; exp_ptr(32'h4); exp_out(0, 0, NOP, 1); next;
    ld_wdata = 32'h0110_0193; exp_ptr(32'h8); next;
    ld_we = 0; ld_start = 1; ld_addr = 32'h10; exp_ptr(32'h10); next;
    ld_start = 0; ld_we = 1; ld_wdata = 32'h3333_3333; exp_ptr(32'h14); next;

    // Fetch the just-written word the cycle ld_en falls, then the first two.
    fetch(32'h10); exp_out(1, 0, 32'h3333_3333, 1); next;
    fetch(32'h0);  exp_out(1, 0, 32'h0140_2103, 1); next;
    fetch(32'h4);  exp_out(1, 0, 32'h0110_0193, 1); exp_ptr(32'h14); next;

    // Boundaries.
    fetch(32'h2);        exp_out(1, 1, NOP, 1); next;
    fetch(32'h7C);       exp_out(1, 0, '0, 0);  next;
    fetch(32'h80);       exp_out(1, 1, NOP, 1); next;
    fetch(32'hFFFF_FFFC); exp_out(1, 1, NOP, 1); next;
    fetch_req = 0;       exp_out(0, 0, NOP, 1); next;

    // Stall holds for three cycles while the address moves; flush beats stall.
    fetch(32'h0); exp_out(1, 0, 32'h0140_2103, 1); next;
    for (int i = 0; i < 3; i++) begin
      stall = 1; fetch_addr = 32'h4; exp_out(1, 0, 32'h0140_2103, 1); next;
    end
    stall = 1; flush = 1; exp_out(0, 0, NOP, 1); next;
    fetch(32'h4); exp_out(1, 0, 32'h0110_0193, 1); next;
    flush = 1;    exp_out(0, 0, NOP, 1); next;

    // Pointer wrap: 0x7C then 0x0.
    flush = 0; fetch_req = 0; ld_en = 1; ld_start = 1; ld_addr = 32'h7C;
    exp_ptr(32'h7C); next;
    ld_start = 0; ld_we = 1; ld_wdata = 32'hDEAD_BEEF; exp_ptr(32'h0); next;
    ld_wdata = 32'hCAFE_F00D; exp_ptr(32'h4); next;
    // ld_start and ld_we together: no write, pointer = 0x93 & ~3 mod 128.
    ld_start = 1; ld_we = 1; ld_addr = 32'h93; ld_wdata = 32'h1111_1111;
    exp_ptr(32'h10); next;

    fetch(32'h7C); exp_out(1, 0, 32'hDEAD_BEEF, 1); next;
    fetch(32'h0);  exp_out(1, 0, 32'hCAFE_F00D, 1); next;
    fetch(32'h10); exp_out(1, 0, 32'h3333_3333, 1); exp_ptr(32'h10); next;
    fetch(32'h4);  exp_out(1, 0, 32'h0110_0193, 1);

    // Asynchronous reset between edges while a valid fetch is held.
    @(posedge clk); #3;
    reset_n = 0; #1;
    chk("async_valid", {31'b0, instr_valid}, 32'd0);
    chk("async_instr", instr_out, NOP);
    chk("async_ptr", ld_ptr, 32'd0);
    next;
    // A write presented during reset must not land at address 0.
    fetch_req = 0; ld_en = 1; ld_we = 1; ld_start = 0; ld_wdata = 32'h9999_9999;
    next;
    chk("rst_hold_ptr", ld_ptr, 32'd0);
    reset_n = 1; fetch(32'h0); exp_out(1, 0, 32'hCAFE_F00D, 1); next;
    fetch_req = 0; exp_out(0, 0, NOP, 1); next;
    next; next;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
